e_multi_rr_feed: RTL and testbench

Round-robin request arbiter and grant-lock stage that sits directly upstream of the multi-cell selection chain. It collects RADIX_N lane requests, chooses one with rotating priority, and holds that choice as a registered one-hot select for the whole packet. Each grant lasts until the downstream accepts the lane's last beat. Its `vld_o`/`sel_o`/`prior_o` outputs drive the chain's `vld_i`/`sel_i`/`prior_i` inputs.

---
 rtl/e_multi_pkg.sv | 29 ++
 rtl/e_multi_rr_pick.sv | 41 ++++
 rtl/e_multi_rr_feed.sv | 106 ++++++++++
 tb/tb_e_multi_rr_feed.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/e_multi_pkg.sv
// Shared types and helpers for the round-robin feed arbiter.
package e_multi_pkg;

  // Two-state grant FSM: waiting for a request, or holding a lane for a packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } e_multi_rr_state_t;

  // Upper bound on lanes the one-hot helper can decode.
  localparam int MAX_RADIX = 32;
  localparam int MAX_IDX_W = 5;

  // Pointer width for a given lane count; never narrower than one bit.
  function automatic int ptr_width(input int radix);
    return (radix <= 2) ? 1 : $clog2(radix);
  endfunction

  // One-hot to binary index; OR-reduction is exact for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_RADIX-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_RADIX; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/e_multi_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping from the top lane back to lane 0.
module e_multi_rr_pick #(
  parameter int RADIX_N = 4,
  parameter int PTR_W   = 2
) (
  input  logic [RADIX_N-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [RADIX_N-1:0] gnt,
  output logic               any
);

  logic [2*RADIX_N-1:0] req_dbl;
  logic [2*RADIX_N-1:0] rot_dbl;
  logic [RADIX_N-1:0]   req_rot;
  logic [RADIX_N-1:0]   first_rot;
  logic [2*RADIX_N-1:0] gnt_dbl;
  logic                 found;

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    // NOTE: every signal gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    first_rot = '0;
    found     = 1'b0;
    req_dbl   = {req, req};
    rot_dbl   = req_dbl >> ptr;
    req_rot   = rot_dbl[RADIX_N-1:0];
    for (int i = 0; i < RADIX_N; i++) begin
      if (req_rot[i] && !found) begin
        first_rot[i] = 1'b1;
        found        = 1'b1;
      end
    end
    gnt_dbl = {first_rot, first_rot} << ptr;
    gnt     = gnt_dbl[2*RADIX_N-1:RADIX_N];
  end

  assign any = |req;

endmodule

// File: rtl/e_multi_rr_feed.sv
// Round-robin request arbiter with grant lock: holds a one-hot lane select for
// a whole packet and re-arbitrates back-to-back on the last accepted beat.
// Supports 2..MAX_RADIX lanes.
module e_multi_rr_feed
  import e_multi_pkg::*;
#(
  parameter int RADIX_N = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [RADIX_N-1:0] req_i,
  input  logic [RADIX_N-1:0] last_i,
  input  logic               ack_i,
  output logic               vld_o,
  output logic [RADIX_N-1:0] sel_o,
  output logic               prior_o,
  output logic [CNT_W-1:0]   beat_cnt_o
);

  localparam int PTR_W = ptr_width(RADIX_N);

  e_multi_rr_state_t  state_q;
  logic [RADIX_N-1:0] sel_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic               accept;
  logic               release_beat;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   rel_ptr;
  logic [CNT_W-1:0]   beat_cnt_inc;
  logic [RADIX_N-1:0] pick_req;
  logic [PTR_W-1:0]   pick_ptr;
  logic [RADIX_N-1:0] pick_gnt;
  logic               pick_any;

  assign accept       = (state_q == LOCK) && ack_i;
  assign release_beat = accept && |(last_i & sel_q);

  // Release pointer, saturating count and the shared picker's inputs; on
  // release the departing lane is masked and the scan starts just past it.
  always_comb begin
    gnt_idx      = PTR_W'(onehot_to_idx(MAX_RADIX'(sel_q)));
    rel_ptr      = (gnt_idx == PTR_W'(RADIX_N - 1)) ? '0 : gnt_idx + 1'b1;
    beat_cnt_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
    pick_req     = release_beat ? (req_i & ~sel_q) : req_i;
    pick_ptr     = release_beat ? rel_ptr : ptr_q;
  end

  e_multi_rr_pick #(
    .RADIX_N (RADIX_N),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Grant FSM with lane select, round-robin pointer and beat counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from
      // the pre-edge values, independent of statement order.
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= LOCK;
            sel_q      <= pick_gnt;
            beat_cnt_q <= '0;
          end
        end
        LOCK: begin
          if (release_beat) begin
            ptr_q      <= rel_ptr;
            beat_cnt_q <= '0;
            if (pick_any) begin
              sel_q <= pick_gnt;
            end else begin
              state_q <= IDLE;
              sel_q   <= '0;
            end
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
        end
      endcase
    end
  end

  assign vld_o      = (state_q == LOCK);
  assign sel_o      = vld_o ? sel_q : '0;
  assign prior_o    = vld_o && (beat_cnt_q != '0);
  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_e_multi_rr_feed.sv
// Bench for e_multi_rr_feed: directed scenarios followed by random traffic,
// checked against a lane-index reference model. A second instance with a
// 2-bit counter shares the same inputs to exercise saturation.
module tb_e_multi_rr_feed;

  localparam int N = 4;

  logic         clk;
  logic         arst_n;
  logic [N-1:0] req_i;
  logic [N-1:0] last_i;
  logic         ack_i;

  logic         vld_o,  vld2_o;
  logic [N-1:0] sel_o,  sel2_o;
  logic         prior_o, prior2_o;
  logic [7:0]   beat_cnt_o;
  logic [1:0]   beat_cnt2_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: granted lane (-1 = none), pointer, beat counts.
  int m_lane = -1;
  int m_ptr  = 0;
  int m_cnt  = 0;
  int m_cnt2 = 0;

  e_multi_rr_feed #(.RADIX_N(N), .CNT_W(8)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_i      (req_i),
    .last_i     (last_i),
    .ack_i      (ack_i),
    .vld_o      (vld_o),
    .sel_o      (sel_o),
    .prior_o    (prior_o),
    .beat_cnt_o (beat_cnt_o)
  );

  e_multi_rr_feed #(.RADIX_N(N), .CNT_W(2)) dut2 (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_i      (req_i),
    .last_i     (last_i),
    .ack_i      (ack_i),
    .vld_o      (vld2_o),
    .sel_o      (sel2_o),
    .prior_o    (prior2_o),
    .beat_cnt_o (beat_cnt2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting lane scanning upward from ptr with wrap; -1 if none.
  function automatic int m_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int l;
      l = (ptr + k) % N;
      if (((req >> l) & 1) != 0) return l;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic m_tick(input logic [N-1:0] req, input logic [N-1:0] last, input logic ack);
    int nl;
    if (m_lane < 0) begin
      nl = m_pick(req, m_ptr);
      if (nl >= 0) begin
        m_lane = nl;
        m_cnt  = 0;
        m_cnt2 = 0;
      end
    end else if (ack) begin
      if (((last >> m_lane) & 1) != 0) begin
        m_ptr  = (m_lane + 1) % N;
        nl     = m_pick(req & ~(N'(1) << m_lane), m_ptr);
        m_lane = nl;
        m_cnt  = 0;
        m_cnt2 = 0;
      end else begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_sel;
    exp_sel = (m_lane >= 0) ? (32'd1 << m_lane) : 32'd0;
    check({tag, ".vld"},   32'(vld_o),       (m_lane >= 0) ? 32'd1 : 32'd0);
    check({tag, ".sel"},   32'(sel_o),       exp_sel);
    check({tag, ".prior"}, 32'(prior_o),     (m_cnt != 0) ? 32'd1 : 32'd0);
    check({tag, ".cnt"},   32'(beat_cnt_o),  32'(m_cnt));
    check({tag, ".cnt2"},  32'(beat_cnt2_o), 32'(m_cnt2));
    check({tag, ".ptr"},   32'(dut.ptr_q),   32'(m_ptr));
  endtask

  // Drive inputs, take one edge, update the model, sample 1 time unit later.
  task automatic step(input string tag, input logic [N-1:0] req,
                      input logic [N-1:0] last, input logic ack);
    req_i  = req;
    last_i = last;
    ack_i  = ack;
    @(posedge clk);
    m_tick(req, last, ack);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, confirm outputs drop at once, release later.
  task automatic do_reset(input string tag);
    #2;
    arst_n = 1'b0;
    req_i  = '0;
    last_i = '0;
    ack_i  = 1'b0;
    #1;
    m_lane = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    m_cnt2 = 0;
    check_all(tag);
    @(posedge clk);
    #3;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0;
    req_i  = '0;
    last_i = '0;
    ack_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2;
    arst_n = 1'b1;

    // Single request on lane 2, held through idle requests until last+ack.
    step("t1.grant", 4'b0100, 4'b0000, 1'b0);
    check("t1.sel2", 32'(sel_o), 32'h4);
    step("t1.hold0", 4'b0000, 4'b0000, 1'b0);
    step("t1.hold1", 4'b0000, 4'b0100, 1'b0);
    step("t1.hold2", 4'b0000, 4'b0000, 1'b1);
    step("t1.rel",   4'b0000, 4'b0100, 1'b1);
    check("t1.ptr3", 32'(dut.ptr_q), 32'd3);
    check("t1.idle", 32'(vld_o), 32'd0);

    // All lanes requesting single-beat packets: full rotation with no bubble.
    do_reset("t2.rst");
    for (int i = 0; i < 6; i++) step("t2.rr", 4'b1111, 4'b1111, 1'b1);

    // Lane 1 three-beat packet; lane 3 requests mid-packet and follows.
    do_reset("t3.rst");
    step("t3.grant", 4'b0010, 4'b0000, 1'b0);
    step("t3.b1",    4'b0010, 4'b0000, 1'b1);
    step("t3.b2",    4'b1000, 4'b0000, 1'b1);
    check("t3.still1", 32'(sel_o), 32'h2);
    step("t3.rel",   4'b1000, 4'b0010, 1'b1);
    check("t3.lane3",  32'(sel_o), 32'h8);

    // Stall with ack low for 10 cycles mid-packet on lane 3.
    step("t4.b1", 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step("t4.stall", 4'b0111, 4'b1111, 1'b0);

    // Long packet drives the 2-bit counter into saturation.
    for (int i = 0; i < 6; i++) step("t5.beat", 4'b0000, 4'b0000, 1'b1);
    check("t5.sat", 32'(beat_cnt2_o), 32'd3);
    step("t5.rel", 4'b0000, 4'b1000, 1'b1);

    // Reset in the middle of a lane-2 grant, then pointer restarts at 0.
    step("t6.grant", 4'b0100, 4'b0000, 1'b0);
    step("t6.b1",    4'b0100, 4'b0000, 1'b1);
    do_reset("t6.rst");
    step("t6.regrant", 4'b0101, 4'b0000, 1'b0);
    check("t6.lane0", 32'(sel_o), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r, l;
      logic a;
      r = N'($urandom_range(0, 15));
      l = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) != 0);
      step("rand", r, l, a);
      if ($urandom_range(0, 199) == 0) do_reset("rand.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
